// File: rtl/game_pkg.sv
// Shared state type and 50 MHz board defaults for the memory-pattern game.
package game_pkg;

   typedef enum logic [2:0] {
      IDLE,
      EXTEND,
      SHOW_ON,
      SHOW_GAP,
      WAIT_IN,
      WIN,
      LOSE
   } state_e;

   localparam int MAX_LEN_DEF        = 16;
   localparam int SYM_W_DEF          = 2;
   localparam int SHOW_CYCLES_DEF    = 25_000_000;
   localparam int GAP_CYCLES_DEF     = 12_500_000;
   localparam int TIMEOUT_CYCLES_DEF = 100_000_000;

   function automatic int max3(int a, int b, int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/pattern_mem.sv
// Pattern register file: one synchronous write port, one combinational read.
module pattern_mem
   import game_pkg::*;
#(
   parameter int MAX_LEN = MAX_LEN_DEF,
   parameter int SYM_W   = SYM_W_DEF,
   parameter int AW      = $clog2(MAX_LEN + 1)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [SYM_W-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [SYM_W-1:0] rdata
);

   // Sized to the full address range so any index is in bounds.
   logic [SYM_W-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/pattern_round_ctrl.sv
// Round sequencer: grows the pattern, plays it back, then checks the player.
module pattern_round_ctrl
   import game_pkg::*;
#(
   parameter int MAX_LEN        = MAX_LEN_DEF,
   parameter int SYM_W          = SYM_W_DEF,
   parameter int SHOW_CYCLES    = SHOW_CYCLES_DEF,
   parameter int GAP_CYCLES     = GAP_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic [SYM_W-1:0]                 lfsr_val,
   output logic                             lfsr_en,
   input  logic                             btn_valid,
   input  logic [SYM_W-1:0]                 btn_sym,
   output logic                             show_valid,
   output logic [SYM_W-1:0]                 show_sym,
   output logic [$clog2(MAX_LEN+1)-1:0]     round_len,
   output logic                             busy,
   output logic                             win,
   output logic                             lose
);

   localparam int LW   = $clog2(MAX_LEN + 1);
   localparam int TMAX = max3(SHOW_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
   localparam int TW   = $clog2(TMAX) + 1;

   localparam logic [TW-1:0] SHOW_END = TW'(SHOW_CYCLES - 1);
   localparam logic [TW-1:0] GAP_END  = TW'(GAP_CYCLES - 1);
   localparam logic [TW-1:0] TO_END   = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);

   state_e           state, state_n;
   logic [LW-1:0]    len, len_n;
   logic [LW-1:0]    idx, idx_n;
   logic [TW-1:0]    timer, timer_n;
   logic             we;
   logic [SYM_W-1:0] rdata;
   logic             last;

   pattern_mem #(
      .MAX_LEN (MAX_LEN),
      .SYM_W   (SYM_W),
      .AW      (LW)
   ) u_mem (
      .clk   (clk),
      .we    (we),
      .waddr (len),
      .wdata (lfsr_val),
      .raddr (idx),
      .rdata (rdata)
   );

   assign last = (idx == len - LW'(1));

   always_comb begin
      state_n = state;
      len_n   = len;
      idx_n   = idx;
      timer_n = '0;
      we      = 1'b0;
      unique case (state)
         IDLE, WIN, LOSE: begin
            if (start) begin
               len_n   = '0;
               state_n = EXTEND;
            end
         end
         EXTEND: begin
            we      = 1'b1;
            len_n   = len + LW'(1);
            idx_n   = '0;
            state_n = SHOW_ON;
         end
         SHOW_ON: begin
            timer_n = timer + TW'(1);
            if (timer == SHOW_END) state_n = SHOW_GAP;
         end
         SHOW_GAP: begin
            timer_n = timer + TW'(1);
            if (timer == GAP_END) begin
               state_n = last ? WAIT_IN : SHOW_ON;
               idx_n   = last ? '0 : idx + LW'(1);
            end
         end
         WAIT_IN: begin
            timer_n = timer + TW'(1);
            // A press on the timeout cycle wins over the timeout.
            if (btn_valid) begin
               if (btn_sym != rdata) begin
                  state_n = LOSE;
               end else if (!last) begin
                  idx_n   = idx + LW'(1);
                  timer_n = '0;
               end else begin
                  state_n = (len == LEN_MAX) ? WIN : EXTEND;
               end
            end else if (timer == TO_END) begin
               state_n = LOSE;
            end
         end
         default: state_n = IDLE;
      endcase
      if (state_n != state) timer_n = '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         len   <= '0;
         idx   <= '0;
         timer <= '0;
      end else begin
         state <= state_n;
         len   <= len_n;
         idx   <= idx_n;
         timer <= timer_n;
      end
   end

   assign lfsr_en    = (state == IDLE) || (state == WAIT_IN) ||
                       (state == WIN)  || (state == LOSE);
   assign show_valid = (state == SHOW_ON);
   assign show_sym   = show_valid ? rdata : '0;
   assign round_len  = len;
   assign busy       = (state == EXTEND)   || (state == SHOW_ON) ||
                       (state == SHOW_GAP) || (state == WAIT_IN);
   assign win        = (state == WIN);
   assign lose       = (state == LOSE);

endmodule

// File: tb/tb_pattern_round_ctrl.sv
// Bench for pattern_round_ctrl: vector table, hand sequences, random games.
module tb_pattern_round_ctrl;

   localparam int ML = 3;
   localparam int SC = 4;
   localparam int GC = 2;
   localparam int TO = 20;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       btn_valid = 1'b0;
   logic [1:0] lfsr_val = 2'd0;
   logic [1:0] btn_sym = 2'd0;
   logic [1:0] show_sym;
   logic [1:0] round_len;
   logic       lfsr_en, show_valid, busy, win, lose;
   logic [8:0] dv;

   int total = 0;
   int bad = 0;
   logic [1:0] pat[$];

   always #5 clk = ~clk;

   pattern_round_ctrl #(
      .MAX_LEN        (ML),
      .SYM_W          (2),
      .SHOW_CYCLES    (SC),
      .GAP_CYCLES     (GC),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .lfsr_val   (lfsr_val),
      .lfsr_en    (lfsr_en),
      .btn_valid  (btn_valid),
      .btn_sym    (btn_sym),
      .show_valid (show_valid),
      .show_sym   (show_sym),
      .round_len  (round_len),
      .busy       (busy),
      .win        (win),
      .lose       (lose)
   );

   assign dv = {lfsr_en, show_valid, show_sym, round_len, busy, win, lose};

   // {lfsr_en, show_valid, show_sym, round_len, busy, win, lose}
   function automatic logic [8:0] ev(bit le, bit sv, logic [1:0] ss,
                                     int rl, bit b, bit w, bit l);
      logic [1:0] r;
      r = 2'(rl);
      return {le, sv, ss, r, b, w, l};
   endfunction

   function automatic logic [8:0] v_idle(int n);
      return ev(1, 0, 2'd0, n, 0, 0, 0);
   endfunction
   function automatic logic [8:0] v_busy(int n);
      return ev(0, 0, 2'd0, n, 1, 0, 0);
   endfunction
   function automatic logic [8:0] v_wait(int n);
      return ev(1, 0, 2'd0, n, 1, 0, 0);
   endfunction
   function automatic logic [8:0] v_win(int n);
      return ev(1, 0, 2'd0, n, 0, 1, 0);
   endfunction
   function automatic logic [8:0] v_lose(int n);
      return ev(1, 0, 2'd0, n, 0, 0, 1);
   endfunction

   // Result of one player entry, from the game rules.
   function automatic logic [8:0] outcome(bit ok, bit tmo, bit last_one);
      int n;
      n = pat.size();
      if (tmo || !ok) return v_lose(n);
      if (!last_one) return v_wait(n);
      if (n == ML) return v_win(n);
      return v_busy(n);
   endfunction

   task automatic chk(input string nm, input logic [8:0] exp);
      total++;
      if (dv !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%b want=%b", nm, $time, dv, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      start = 1'b0;
      btn_valid = 1'b0;
      #1;
      chk("reset_async", v_idle(0));
      tick();
      reset = 1'b1;
      tick();
      pat.delete();
      chk("reset_idle", v_idle(0));
   endtask

   // Called in the EXTEND cycle: appends v and checks the full playback.
   task automatic new_round(input logic [1:0] v, input bit noise);
      chk("extend", v_busy(pat.size()));
      lfsr_val = v;
      pat.push_back(v);
      for (int i = 0; i < pat.size(); i++) begin
         for (int c = 0; c < SC; c++) begin
            if (noise) begin
               btn_valid = 1'b1;
               btn_sym = ~pat[i];
            end
            tick();
            lfsr_val = 2'($urandom);
            chk("show_on", ev(0, 1, pat[i], pat.size(), 1, 0, 0));
         end
         for (int c = 0; c < GC; c++) begin
            if (noise) begin
               btn_valid = 1'b1;
               btn_sym = ~pat[i];
            end
            tick();
            chk("show_gap", v_busy(pat.size()));
         end
      end
      btn_valid = 1'b0;
      tick();
      chk("wait_in", v_wait(pat.size()));
   endtask

   // From a WAIT_IN timer-zero cycle: idle d cycles, then press (d<TO).
   task automatic enter(input logic [1:0] sym, input int d);
      int w;
      w = (d >= TO) ? TO - 1 : d;
      for (int k = 0; k < w; k++) begin
         tick();
         chk("wait_hold", v_wait(pat.size()));
      end
      if (d < TO) begin
         btn_valid = 1'b1;
         btn_sym = sym;
      end
      tick();
      btn_valid = 1'b0;
   endtask

   task automatic begin_game(input bit hold);
      start = 1'b1;
      lfsr_val = 2'($urandom);
      tick();
      if (!hold) start = 1'b0;
      pat.delete();
   endtask

   task automatic rand_game();
      bit done;
      int d;
      logic [1:0] s;
      logic [8:0] e;
      done = 1'b0;
      begin_game(1'b0);
      while (!done) begin
         new_round(2'($urandom), 1'($urandom_range(0, 1)));
         for (int i = 0; i < pat.size() && !done; i++) begin
            if ($urandom_range(0, 7) == 0) d = $urandom_range(TO, TO + 2);
            else d = $urandom_range(0, TO - 1);
            if ($urandom_range(0, 5) == 0) s = 2'($urandom);
            else s = pat[i];
            e = outcome(s == pat[i], d >= TO, i == pat.size() - 1);
            enter(s, d);
            chk("rand_entry", e);
            if (e[1] || e[0]) done = 1'b1;
         end
      end
   endtask

   typedef struct {
      logic [1:0] lfsr;
      logic [1:0] btn;
      int         delay;
      logic [8:0] exp;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #1_000_000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{2'd2, 2'd0, 0,  v_lose(1)};
      vecs[1] = '{2'd2, 2'd2, 0,  v_busy(1)};
      vecs[2] = '{2'd1, 2'd1, 19, v_busy(1)};
      vecs[3] = '{2'd3, 2'd3, 20, v_lose(1)};
      vecs[4] = '{2'd0, 2'd1, 5,  v_lose(1)};
      vecs[5] = '{2'd3, 2'd3, 7,  v_busy(1)};

      // Reset then ten idle cycles.
      #1;
      chk("reset_async", v_idle(0));
      tick();
      tick();
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle", v_idle(0));
      end

      // Single-round entry table, including the timeout boundary.
      foreach (vecs[r]) begin
         do_reset();
         begin_game(1'b0);
         new_round(vecs[r].lfsr, 1'b0);
         enter(vecs[r].btn, vecs[r].delay);
         chk($sformatf("vec%0d", r), vecs[r].exp);
      end

      // Full game to a win.
      do_reset();
      begin_game(1'b0);
      new_round(2'd2, 1'b0);
      enter(2'd2, 0);
      chk("r1_done", v_busy(1));
      new_round(2'd1, 1'b0);
      enter(2'd2, 1);
      chk("r2_e0", v_wait(2));
      enter(2'd1, 0);
      chk("r2_done", v_busy(2));
      new_round(2'd3, 1'b0);
      enter(2'd2, 0);
      enter(2'd1, 2);
      enter(2'd3, 0);
      chk("win", v_win(3));
      tick();
      chk("win_hold", v_win(3));

      // Held start restarts from WIN and is ignored mid-game; noise presses.
      begin_game(1'b1);
      new_round(2'd0, 1'b1);
      enter(2'd3, 0);
      chk("lose_wrong", v_lose(1));
      tick();
      pat.delete();
      chk("restart_held", v_busy(0));
      start = 1'b0;
      new_round(2'd1, 1'b0);

      // Reset during round-2 playback.
      enter(2'd1, 0);
      chk("r1_ok", v_busy(1));
      lfsr_val = 2'd2;
      tick();
      tick();
      chk("show_mid", ev(0, 1, 2'd1, 2, 1, 0, 0));
      do_reset();

      // Random games against the rule model.
      for (int g = 0; g < 40; g++) rand_game();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
